// File: rtl/alu_exec_unit_if.sv
// Execute-stage ALU handshake bundle.
// Request side (ctrl/operands) and response side (result/flags).
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             div_by_zero;
  logic             illegal;

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, hi, zero,
    output div_by_zero, illegal
  );

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, hi, zero,
    input  div_by_zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: 1-cycle logic/arith ops,
// iterative signed MUL/DIV over WIDTH cycles.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  alu_exec_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] wh_q, wh_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hio_q, hio_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0]   a, b, abs_a, abs_b;
  logic [WIDTH:0]     sum, sh;
  logic [WIDTH-1:0]   diff;
  logic               ge, last, load;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic [WIDTH-1:0]   div_hi, div_lo;

  assign a     = bus.op_a;
  assign b     = bus.op_b;
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  // One shift-add step and one restoring-divide step on magnitudes
  always_comb begin
    sum    = {1'b0, wh_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    mul_hi = sum[WIDTH:1];
    mul_lo = {sum[0], lo_q[WIDTH-1:1]};
    prod   = {mul_hi, mul_lo};
    prod_s = negq_q ? -prod : prod;
    sh     = {wh_q, lo_q[WIDTH-1]};
    ge     = sh >= {1'b0, mag_q};
    diff   = sh[WIDTH-1:0] - mag_q;
    div_hi = ge ? diff : sh[WIDTH-1:0];
    div_lo = {lo_q[WIDTH-2:0], ge};
    last   = cnt_q == CW'(WIDTH - 1);
  end

  // Next-state and result datapath
  always_comb begin
    state_d = state_q;
    wh_d    = wh_q;
    lo_d    = lo_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    hio_d   = hio_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    ill_d   = ill_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          load  = 1'b1;
          hio_d = '0;
          cnt_d = '0;
          case (bus.alu_ctrl)
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_ADD: res_d = a + b;
            OP_SUB: res_d = a - b;
            OP_SLT: res_d = {{(WIDTH-1){1'b0}},
                             $signed(a) < $signed(b)};
            OP_MUL: begin
              load   = 1'b0;
              wh_d   = '0;
              lo_d   = abs_b;
              mag_d  = abs_a;
              negq_d = a[WIDTH-1] ^ b[WIDTH-1];
            end
            OP_DIV: begin
              if (b == '0) begin
                res_d = '1;
                hio_d = a;
                dbz_d = 1'b1;
              end else begin
                load   = 1'b0;
                wh_d   = '0;
                lo_d   = abs_a;
                mag_d  = abs_b;
                negq_d = a[WIDTH-1] ^ b[WIDTH-1];
                negr_d = a[WIDTH-1];
              end
            end
            default: begin
              res_d = '0;
              ill_d = 1'b1;
            end
          endcase
          if (load) state_d = S_DONE;
          else if (bus.alu_ctrl == OP_MUL) state_d = S_MUL;
          else state_d = S_DIV;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + CW'(1);
        wh_d  = mul_hi;
        lo_d  = mul_lo;
        if (last) begin
          load    = 1'b1;
          res_d   = prod_s[WIDTH-1:0];
          hio_d   = prod_s[2*WIDTH-1:WIDTH];
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + CW'(1);
        wh_d  = div_hi;
        lo_d  = div_lo;
        if (last) begin
          load    = 1'b1;
          res_d   = negq_q ? -div_lo : div_lo;
          hio_d   = negr_q ? -div_hi : div_hi;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          res_d   = '0;
          hio_d   = '0;
          zero_d  = 1'b0;
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) zero_d = res_d == '0;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wh_q    <= '0;
      lo_q    <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
      hio_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wh_q    <= wh_d;
      lo_q    <= lo_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
      hio_q   <= hio_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.in_ready    = state_q == S_IDLE;
  assign bus.out_valid   = state_q == S_DONE;
  assign bus.result      = res_q;
  assign bus.hi          = hio_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal     = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus
// random ops against a plain-arithmetic model.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] c,
                       input logic [31:0] a, b,
                       output logic [31:0] r, h,
                       output logic dz, il,
                       output int lat);
    longint sa, sb;
    logic [63:0] v, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; h = '0; dz = 0; il = 0; lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0101: begin
        v = sa * sb;
        r = v[31:0];
        h = v[63:32];
        lat = W + 1;
      end
      4'b0100: begin
        if (b == 0) begin
          r = '1; h = a; dz = 1;
        end else begin
          v = sa / sb;
          m = sa % sb;
          r = v[31:0];
          h = m[31:0];
          lat = W + 1;
        end
      end
      default: il = 1;
    endcase
  endtask

  task automatic run_op(input logic [3:0] c,
                        input logic [31:0] a, b,
                        input int hold);
    logic [31:0] er, eh;
    logic edz, eil;
    int elat, lat;
    string t;
    model(c, a, b, er, eh, edz, eil, elat);
    t = $sformatf("op%b a=%h b=%h", c, a, b);
    @(negedge clk);
    chk({t, " in_ready idle"}, 64'(bus.in_ready), 1);
    bus.in_valid = 1; bus.alu_ctrl = c;
    bus.op_a = a; bus.op_b = b; bus.out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 0;
    bus.alu_ctrl = 4'($urandom);
    bus.op_a = $urandom; bus.op_b = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({t, " latency"}, 64'(lat), 64'(elat));
    chk({t, " result"}, 64'(bus.result), 64'(er));
    chk({t, " hi"}, 64'(bus.hi), 64'(eh));
    chk({t, " zero"}, 64'(bus.zero), 64'(er == 0));
    chk({t, " dbz"}, 64'(bus.div_by_zero), 64'(edz));
    chk({t, " illegal"}, 64'(bus.illegal), 64'(eil));
    chk({t, " in_ready busy"}, 64'(bus.in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({t, " hold valid"}, 64'(bus.out_valid), 1);
      chk({t, " hold result"}, 64'(bus.result), 64'(er));
      chk({t, " hold hi"}, 64'(bus.hi), 64'(eh));
      chk({t, " hold in_ready"}, 64'(bus.in_ready), 0);
    end
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    chk({t, " drain valid"}, 64'(bus.out_valid), 0);
    chk({t, " drain in_ready"}, 64'(bus.in_ready), 1);
    chk({t, " drain flags"},
        64'({bus.div_by_zero, bus.illegal}), 0);
  endtask

  task automatic chk_reset_state(input string t);
    chk({t, " in_ready"}, 64'(bus.in_ready), 1);
    chk({t, " out_valid"}, 64'(bus.out_valid), 0);
    chk({t, " result"}, 64'(bus.result), 0);
    chk({t, " hi"}, 64'(bus.hi), 0);
    chk({t, " flags"},
        64'({bus.zero, bus.div_by_zero, bus.illegal}), 0);
  endtask

  logic [3:0] legal [7] = '{4'b0000, 4'b0001, 4'b0010,
                           4'b0110, 4'b0111, 4'b0101, 4'b0100};
  logic [31:0] spec [4] = '{32'h0, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'h1};

  function automatic logic [31:0] rnd_opnd();
    if ($urandom_range(0, 3) == 0)
      return spec[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    logic [3:0] c;
    logic [31:0] a, b;
    bus.in_valid = 0; bus.alu_ctrl = 0;
    bus.op_a = 0; bus.op_b = 0; bus.out_ready = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk_reset_state("reset");

    run_op(4'b0010, 32'd7, 32'd5, 0);
    run_op(4'b0110, 32'd5, 32'd5, 0);
    run_op(4'b0111, -32'sd3, 32'd2, 0);
    run_op(4'b0111, 32'd2, -32'sd3, 0);
    run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_op(4'b0001, 32'hF000_0000, 32'h0000_000F, 0);
    run_op(4'b0101, -32'sd6, 32'd7, 0);
    run_op(4'b0101, 32'h8000_0000, 32'd2, 0);
    run_op(4'b0100, -32'sd7, 32'd2, 0);
    run_op(4'b0100, 32'd9, 32'd0, 0);
    run_op(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(4'b0100, 32'd7, -32'sd2, 0);
    run_op(4'b0101, 32'd1234, -32'sd99, 5);
    run_op(4'b1111, 32'd3, 32'd4, 0);

    @(negedge clk);
    bus.in_valid = 1; bus.alu_ctrl = 4'b0101;
    bus.op_a = 32'd100; bus.op_b = 32'd200;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk_reset_state("mid-mul reset");
    repeat (W + 3) begin
      @(negedge clk);
      chk("post-reset no result", 64'(bus.out_valid), 0);
    end

    for (int i = 0; i < 40; i++) begin
      c = legal[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) c = 4'($urandom);
      a = rnd_opnd();
      b = rnd_opnd();
      if (c == 4'b0100 && $urandom_range(0, 5) == 0) b = 0;
      run_op(c, a, b, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
